// File: rtl/memory_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : memory_game_sequencer
//  Purpose  : Game-control stage of the memory-tester game. Fills a
//             pseudo-random colour sequence, shows it on four one-hot LEDs
//             paced by the timeout generator's tick, checks the player's
//             keys, and starts/stops the timeout generator.
//  Revision : 1.0  initial release
// ============================================================================
module memory_game_sequencer #(
  parameter int         MAX_LEN     = 16,
  parameter int         INPUT_TICKS = 4,
  parameter logic [7:0] FIXED_SEED  = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_btn,
  input  logic                         tick,
  input  logic                         key_valid,
  input  logic [1:0]                   key_code,
  output logic                         tmr_start,
  output logic                         tmr_stop,
  output logic [3:0]                   led,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         win,
  output logic                         lose
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(INPUT_TICKS + 1);

  localparam logic [LW-1:0] LV_ONE    = LW'(1);
  localparam logic [LW-1:0] LV_MAX    = LW'(MAX_LEN);
  localparam logic [IW-1:0] FILL_ONE  = IW'(1);
  localparam logic [IW-1:0] FILL_LAST = IW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TK_ONE    = TW'(1);
  localparam logic [TW-1:0] TK_LIMIT  = TW'(INPUT_TICKS);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FILL     = 3'd1;
  localparam logic [2:0] ST_SHOW_ON  = 3'd2;
  localparam logic [2:0] ST_SHOW_OFF = 3'd3;
  localparam logic [2:0] ST_INPUT    = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;
  localparam logic [2:0] ST_WIN      = 3'd6;
  localparam logic [2:0] ST_LOSE     = 3'd7;

  logic [2:0]    state, state_next;
  logic [LW-1:0] idx, idx_next, idx_inc;
  logic [IW-1:0] fill_idx, fill_idx_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next, tick_cnt_inc;
  logic [LW-1:0] level_next;
  logic [7:0]    lfsr, lfsr_next, lfsr_step;
  logic [7:0]    cnt;
  logic [7:0]    seed_pick, seed;
  logic          fill_done;
  logic          seq_we;
  logic [1:0]    seq [MAX_LEN];
  logic [1:0]    seq_cur;

  logic          tmr_start_next, tmr_stop_next, busy_next, win_next, lose_next;
  logic [3:0]    led_next;

  // Shared arithmetic: LFSR step, seed selection and index increments
  always_comb begin
    lfsr_step    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    seed_pick    = (FIXED_SEED != 8'h00) ? FIXED_SEED : cnt;
    seed         = (seed_pick == 8'h00) ? 8'hA5 : seed_pick;
    idx_inc      = idx + LV_ONE;
    tick_cnt_inc = tick_cnt + TK_ONE;
    seq_cur      = seq[idx[IW-1:0]];
  end

  // State register, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      fill_idx  <= '0;
      tick_cnt  <= '0;
      lfsr      <= '0;
      cnt       <= '0;
      level     <= '0;
      led       <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      tmr_start <= 1'b0;
      tmr_stop  <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      fill_idx  <= fill_idx_next;
      tick_cnt  <= tick_cnt_next;
      lfsr      <= lfsr_next;
      cnt       <= cnt + 8'd1;
      level     <= level_next;
      led       <= led_next;
      busy      <= busy_next;
      win       <= win_next;
      lose      <= lose_next;
      tmr_start <= tmr_start_next;
      tmr_stop  <= tmr_stop_next;
    end
  end

  // Sequence storage survives reset; written only while filling
  always_ff @(posedge clk) begin
    if (rst && seq_we) begin
      seq[fill_idx] <= lfsr[1:0];
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    fill_idx_next = fill_idx;
    tick_cnt_next = tick_cnt;
    lfsr_next     = lfsr;
    level_next    = level;
    fill_done     = 1'b0;
    seq_we        = 1'b0;
    unique case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_btn) begin
          state_next    = ST_FILL;
          lfsr_next     = seed;
          level_next    = LV_ONE;
          fill_idx_next = '0;
          idx_next      = '0;
        end
      end
      ST_FILL: begin
        seq_we        = 1'b1;
        lfsr_next     = lfsr_step;
        fill_idx_next = fill_idx + FILL_ONE;
        if (fill_idx == FILL_LAST) begin
          fill_done  = 1'b1;
          state_next = ST_SHOW_ON;
          idx_next   = '0;
        end
      end
      ST_SHOW_ON: begin
        if (tick) begin
          state_next = ST_SHOW_OFF;
        end
      end
      ST_SHOW_OFF: begin
        if (tick) begin
          if (idx_inc == level) begin
            state_next    = ST_INPUT;
            idx_next      = '0;
            tick_cnt_next = '0;
          end else begin
            state_next = ST_SHOW_ON;
            idx_next   = idx_inc;
          end
        end
      end
      ST_INPUT: begin
        // A key that ends the phase outranks a same-cycle tick; otherwise
        // the tick is still counted toward the timeout.
        if (key_valid && (key_code != seq_cur)) begin
          state_next = ST_LOSE;
        end else if (key_valid && (idx_inc == level)) begin
          if (level == LV_MAX) begin
            state_next = ST_WIN;
          end else begin
            level_next = level + LV_ONE;
            state_next = ST_GAP;
          end
        end else begin
          if (key_valid) begin
            idx_next = idx_inc;
          end
          if (tick) begin
            if (tick_cnt_inc == TK_LIMIT) begin
              state_next = ST_LOSE;
            end else begin
              tick_cnt_next = tick_cnt_inc;
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_next = ST_SHOW_ON;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    led_next       = 4'b0000;
    busy_next      = 1'b1;
    win_next       = 1'b0;
    lose_next      = 1'b0;
    tmr_start_next = fill_done;
    tmr_stop_next  = 1'b0;
    if (state_next == ST_SHOW_ON) begin
      led_next = 4'b0001 << seq[idx_next[IW-1:0]];
    end
    if ((state_next == ST_IDLE) || (state_next == ST_WIN) || (state_next == ST_LOSE)) begin
      busy_next = 1'b0;
    end
    if (state_next == ST_WIN) begin
      win_next = 1'b1;
    end
    if (state_next == ST_LOSE) begin
      lose_next = 1'b1;
    end
    if ((state_next != state) && ((state_next == ST_WIN) || (state_next == ST_LOSE))) begin
      tmr_stop_next = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_game_sequencer
//  Purpose  : Self-checking bench for memory_game_sequencer. Plays directed
//             and randomized games against a game-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_game_sequencer;

  localparam int         MAX_LEN     = 4;
  localparam int         INPUT_TICKS = 4;
  localparam logic [7:0] SEED        = 8'h01;
  localparam int         LW          = $clog2(MAX_LEN + 1);

  localparam int M_OK      = 0;
  localparam int M_WRONG   = 1;
  localparam int M_TIMEOUT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_btn = 1'b0;
  logic          tick = 1'b0;
  logic          key_valid = 1'b0;
  logic [1:0]    key_code = 2'd0;
  logic          tmr_start, tmr_stop, busy, win, lose;
  logic [3:0]    led;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int seq_m [MAX_LEN];

  always #5 clk = ~clk;

  memory_game_sequencer #(
    .MAX_LEN    (MAX_LEN),
    .INPUT_TICKS(INPUT_TICKS),
    .FIXED_SEED (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .tick     (tick),
    .key_valid(key_valid),
    .key_code (key_code),
    .tmr_start(tmr_start),
    .tmr_stop (tmr_stop),
    .led      (led),
    .level    (level),
    .busy     (busy),
    .win      (win),
    .lose     (lose)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Colour sequence straight from the LFSR definition
  task automatic build_model();
    int s;
    s = (SEED == 8'h00) ? 8'hA5 : int'(SEED);
    for (int i = 0; i < MAX_LEN; i++) begin
      seq_m[i] = s & 3;
      s = ((s << 1) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1)) & 8'hFF;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {20'd0, tmr_start, tmr_stop, led, busy, win, lose, {(3-LW+2){1'b0}}, level},
          32'd0);
  endtask

  task automatic start_game();
    int k;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("start_level", level, 1);
    check("start_busy", busy, 1);
    check("start_flags", {win, lose}, 0);
    k = 0;
    while (!tmr_start && k < 20) begin
      step();
      k++;
    end
    check("tmr_start_latency", k, 4);
    check("first_led", led, 1 << seq_m[0]);
    step();
    check("tmr_start_width", tmr_start, 0);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Show phase: each element lit until a tick, dark until the next tick
  task automatic show_phase(input int lvl);
    for (int i = 0; i < lvl; i++) begin
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 2))
          0: begin key_valid = 1'b1; key_code = 2'($urandom_range(0, 3)); end
          1: start_btn = 1'b1;
          default: ;
        endcase
        step();
        key_valid = 1'b0;
        start_btn = 1'b0;
      end
      check("show_on", led, 1 << seq_m[i]);
      check("show_busy", busy, 1);
      pulse_tick();
      check("show_off", led, 0);
      repeat ($urandom_range(0, 2)) step();
      pulse_tick();
    end
    check("input_led", led, 0);
    check("input_level", level, lvl);
  endtask

  task automatic expect_end(input bit won, input int lvl);
    check("end_win", win, won);
    check("end_lose", lose, !won);
    check("end_tmr_stop", tmr_stop, 1);
    check("end_busy", busy, 0);
    check("end_led", led, 0);
    check("end_level", level, lvl);
    step();
    check("end_tmr_stop_width", tmr_stop, 0);
    check("end_hold", {win, lose}, {won, !won});
  endtask

  // Input phase; done is set when the game has ended
  task automatic play_input(input int lvl, input int mode, input int p, input bit edge_case,
                            output bit done);
    int used;
    bit final_key;
    used = 0;
    done = 1'b0;
    for (int i = 0; i < lvl; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if (used < INPUT_TICKS - 1 && $urandom_range(0, 1) == 1) begin
          tick = 1'b1;
          used++;
        end
        step();
        tick = 1'b0;
      end
      if (mode == M_TIMEOUT && i == p) begin
        while (used < INPUT_TICKS) begin
          check("timeout_not_yet", lose, 0);
          tick = 1'b1;
          used++;
          step();
          tick = 1'b0;
        end
        expect_end(1'b0, lvl);
        done = 1'b1;
        return;
      end
      final_key = (i == lvl - 1);
      if (final_key && edge_case) begin
        while (used < INPUT_TICKS - 1) begin
          tick = 1'b1;
          used++;
          step();
          tick = 1'b0;
        end
        tick = 1'b1;
      end else if (used < INPUT_TICKS - 1 && $urandom_range(0, 2) == 0) begin
        tick = 1'b1;
        used++;
      end
      key_valid = 1'b1;
      if (mode == M_WRONG && i == p) begin
        key_code = 2'((seq_m[i] + $urandom_range(1, 3)) % 4);
      end else begin
        key_code = 2'(seq_m[i]);
      end
      step();
      key_valid = 1'b0;
      tick = 1'b0;
      if (mode == M_WRONG && i == p) begin
        expect_end(1'b0, lvl);
        done = 1'b1;
        return;
      end
      if (!final_key) begin
        check("input_mid_lose", lose, 0);
      end
    end
    if (lvl == MAX_LEN) begin
      expect_end(1'b1, lvl);
      done = 1'b1;
    end else begin
      check("pass_level", level, lvl + 1);
      check("pass_lose", lose, 0);
      check("pass_led", led, 0);
      check("pass_busy", busy, 1);
    end
  endtask

  task automatic play_game(input int fail_lvl, input int mode, input int p, input int edge_lvl);
    bit done;
    start_game();
    for (int lvl = 1; lvl <= MAX_LEN; lvl++) begin
      if (lvl > 1) begin
        repeat ($urandom_range(0, 2)) step();
        check("gap_led", led, 0);
        pulse_tick();
      end
      show_phase(lvl);
      play_input(lvl, (lvl == fail_lvl) ? mode : M_OK, (p < lvl) ? p : lvl - 1,
                 lvl == edge_lvl, done);
      if (done) return;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    rst = 1'b0;
    start_btn = 1'b1;
    repeat (3) step();
    check_all_zero("reset_outputs");
    start_btn = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("idle_outputs");

    // Full win, with the final key of level 2 landing on the last allowed tick
    play_game(0, M_OK, 0, 2);
    // Wrong second key at level 2
    play_game(2, M_WRONG, 1, 0);
    // No keys at level 1 until the tick budget runs out
    play_game(1, M_TIMEOUT, 0, 0);
    // Final key coincides with the last tick on the winning level
    play_game(0, M_OK, 0, MAX_LEN);

    // Reset during the show phase
    start_game();
    repeat ($urandom_range(0, 3)) step();
    rst = 1'b0;
    step();
    check_all_zero("mid_game_reset");
    rst = 1'b1;
    step();
    check_all_zero("after_mid_reset");

    for (int g = 0; g < 8; g++) begin
      play_game($urandom_range(1, MAX_LEN + 1), $urandom_range(1, 2),
                $urandom_range(0, MAX_LEN - 1), $urandom_range(1, MAX_LEN + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
